// File: rtl/bitty_pkg.sv
// Shared definitions for the Bitty control unit: ALU opcodes, instruction formats,
// FSM states and instruction field positions.
package bitty_pkg;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SHL = 3'd5;
  localparam logic [2:0] ALU_SHR = 3'd6;
  localparam logic [2:0] ALU_CMP = 3'd7;

  localparam logic [1:0] FMT_R = 2'b00;
  localparam logic [1:0] FMT_I = 2'b01;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned RX_MSB  = 15;
  localparam int unsigned RX_LSB  = 13;
  localparam int unsigned RY_MSB  = 12;
  localparam int unsigned RY_LSB  = 10;
  localparam int unsigned IMM_MSB = 12;
  localparam int unsigned IMM_LSB = 5;
  localparam int unsigned SEL_MSB = 4;
  localparam int unsigned SEL_LSB = 2;
  localparam int unsigned FMT_MSB = 1;
  localparam int unsigned FMT_LSB = 0;

  typedef enum logic [1:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK
  } state_t;

  function automatic logic is_reserved_fmt(input logic [1:0] fmt);
    return (fmt != FMT_R) && (fmt != FMT_I);
  endfunction

endpackage

// File: rtl/bitty_control_unit_if.sv
// Instruction handshake, ALU drive and writeback report bundle for the Bitty control unit.
interface bitty_control_unit_if #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NUM_REGS = 8
);
  logic                        instr_valid;
  logic [15:0]                 instr;
  logic                        instr_ready;
  logic [2:0]                  alu_select;
  logic [DATA_W-1:0]           alu_in_a;
  logic [DATA_W-1:0]           alu_in_b;
  logic [DATA_W-1:0]           alu_out;
  logic                        done;
  logic                        illegal;
  logic [$clog2(NUM_REGS)-1:0] wb_addr;
  logic [DATA_W-1:0]           wb_data;

  // Control unit side.
  modport slave (
    input  instr_valid, instr, alu_out,
    output instr_ready, alu_select, alu_in_a, alu_in_b, done, illegal, wb_addr, wb_data
  );

  // Fetch logic / ALU / observer side.
  modport master (
    output instr_valid, instr, alu_out,
    input  instr_ready, alu_select, alu_in_a, alu_in_b, done, illegal, wb_addr, wb_data
  );
endinterface

// File: rtl/bitty_regfile.sv
// NUM_REGS x DATA_W register file: two asynchronous read ports, one synchronous write port,
// asynchronous active-low clear.
module bitty_regfile #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned AW       = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr_a,
  output logic [DATA_W-1:0] o_rdata_a,
  input  logic [AW-1:0]     i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_b
);

  logic [DATA_W-1:0] r_mem [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/bitty_control_unit.sv
// Bitty multi-cycle sequencer: FETCH -> DECODE -> EXECUTE -> WRITEBACK around an external ALU.
// Build option IMM_SIGN_EXT_EN: sign-extend the I-type imm8 (default is zero-extension).
module bitty_control_unit
  import bitty_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NUM_REGS = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  bitty_control_unit_if.slave bus
);

  localparam int unsigned AW = $clog2(NUM_REGS);

  state_t              r_state;
  logic [INSTR_W-1:0]  r_ir;
  logic                r_instr_ready;
  logic [2:0]          r_alu_select;
  logic [DATA_W-1:0]   r_alu_in_a;
  logic [DATA_W-1:0]   r_alu_in_b;
  logic                r_done;
  logic                r_illegal;
  logic [AW-1:0]       r_wb_addr;
  logic [DATA_W-1:0]   r_wb_data;

  logic [AW-1:0]       w_rx;
  logic [AW-1:0]       w_ry;
  logic [7:0]          w_imm8;
  logic [2:0]          w_sel;
  logic [1:0]          w_fmt;
  logic [DATA_W-1:0]   w_imm_ext;
  logic [DATA_W-1:0]   w_rd_a;
  logic [DATA_W-1:0]   w_rd_b;
  logic                w_handshake;
  logic                w_we;

  assign w_rx   = r_ir[RX_MSB:RX_LSB];
  assign w_ry   = r_ir[RY_MSB:RY_LSB];
  assign w_imm8 = r_ir[IMM_MSB:IMM_LSB];
  assign w_sel  = r_ir[SEL_MSB:SEL_LSB];
  assign w_fmt  = r_ir[FMT_MSB:FMT_LSB];

`ifdef IMM_SIGN_EXT_EN
  assign w_imm_ext = {{(DATA_W-8){w_imm8[7]}}, w_imm8};
`else
  assign w_imm_ext = {{(DATA_W-8){1'b0}}, w_imm8};
`endif

  assign w_handshake = bus.instr_valid & r_instr_ready;

  // The write lands at the end of WRITEBACK, so a read in the same instruction's DECODE
  // always sees the pre-write value.
  assign w_we = (r_state == S_WRITEBACK);

  bitty_regfile #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .AW       (AW)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (reset_n),
    .i_we      (w_we),
    .i_waddr   (r_wb_addr),
    .i_wdata   (r_wb_data),
    .i_raddr_a (w_rx),
    .o_rdata_a (w_rd_a),
    .i_raddr_b (w_ry),
    .o_rdata_b (w_rd_b)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_FETCH;
      r_ir          <= '0;
      r_instr_ready <= 1'b1;
      r_alu_select  <= '0;
      r_alu_in_a    <= '0;
      r_alu_in_b    <= '0;
      r_done        <= 1'b0;
      r_illegal     <= 1'b0;
      r_wb_addr     <= '0;
      r_wb_data     <= '0;
    end else begin
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      case (r_state)
        S_FETCH: begin
          if (w_handshake) begin
            r_ir          <= bus.instr;
            r_instr_ready <= 1'b0;
            // Flagged here so the pulse is visible during the DECODE cycle itself.
            r_illegal     <= is_reserved_fmt(bus.instr[FMT_MSB:FMT_LSB]);
            r_state       <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (is_reserved_fmt(w_fmt)) begin
            r_instr_ready <= 1'b1;
            r_state       <= S_FETCH;
          end else begin
            r_alu_in_a   <= w_rd_a;
            r_alu_in_b   <= (w_fmt == FMT_I) ? w_imm_ext : w_rd_b;
            r_alu_select <= w_sel;
            r_state      <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          r_wb_data <= bus.alu_out;
          r_wb_addr <= w_rx;
          r_done    <= 1'b1;
          r_state   <= S_WRITEBACK;
        end
        S_WRITEBACK: begin
          r_instr_ready <= 1'b1;
          r_state       <= S_FETCH;
        end
        default: begin
          r_instr_ready <= 1'b1;
          r_state       <= S_FETCH;
        end
      endcase
    end
  end

  assign bus.instr_ready = r_instr_ready;
  assign bus.alu_select  = r_alu_select;
  assign bus.alu_in_a    = r_alu_in_a;
  assign bus.alu_in_b    = r_alu_in_b;
  assign bus.done        = r_done;
  assign bus.illegal     = r_illegal;
  assign bus.wb_addr     = r_wb_addr;
  assign bus.wb_data     = r_wb_data;

endmodule

// File: tb/tb_bitty_control_unit.sv
// Directed bench for bitty_control_unit with a behavioural 16-bit ALU attached.
module tb_bitty_control_unit;
  import bitty_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  bitty_control_unit_if #(.DATA_W(16), .NUM_REGS(8)) bus();

  bitty_control_unit #(.DATA_W(16), .NUM_REGS(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Reference ALU; CMP returns 0 (equal), 2 (a > b), 1 (a < b).
  function automatic logic [15:0] alu_model(input logic [2:0] sel, input logic [15:0] a,
                                            input logic [15:0] b);
    case (sel)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      ALU_SHL: return a << b[3:0];
      ALU_SHR: return a >> b[3:0];
      default: return (a == b) ? 16'd0 : ((a > b) ? 16'd2 : 16'd1);
    endcase
  endfunction

  assign bus.alu_out = alu_model(bus.alu_select, bus.alu_in_a, bus.alu_in_b);

  function automatic logic [15:0] enc_r(input logic [2:0] rx, input logic [2:0] ry,
                                        input logic [2:0] sel);
    return {rx, ry, 5'b0, sel, FMT_R};
  endfunction

  function automatic logic [15:0] enc_i(input logic [2:0] rx, input logic [7:0] imm,
                                        input logic [2:0] sel);
    return {rx, imm, sel, FMT_I};
  endfunction

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.instr_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Issues one instruction and checks the 4-cycle timeline against expected writeback.
  task automatic run_instr(input string name, input logic [15:0] ins, input logic [2:0] ea,
                           input logic [15:0] ed);
    bit ok;
    wait_ready(ok);
    n_checks++;
    if (!ok) $display("FAIL %s_ready_wait: instr_ready never rose", name);
    else n_pass++;
    bus.instr_valid = 1'b1;
    bus.instr       = ins;
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    bus.instr       = 16'($urandom);
    @(negedge clk);
    n_checks++;
    if ({bus.done, bus.instr_ready} !== 2'b00)
      $display("FAIL %s_decode: done,ready=%b required 00", name, {bus.done, bus.instr_ready});
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({bus.done, bus.wb_addr, bus.wb_data} !== {1'b1, ea, ed})
      $display("FAIL %s_writeback: done=%b addr=%0d data=%h required done=1 addr=%0d data=%h",
               name, bus.done, bus.wb_addr, bus.wb_data, ea, ed);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({bus.instr_ready, bus.done} !== 2'b10)
      $display("FAIL %s_refetch: ready,done=%b required 10", name, {bus.instr_ready, bus.done});
    else n_pass++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.instr_ready, bus.done, bus.illegal, bus.wb_addr, bus.wb_data, bus.alu_select,
         bus.alu_in_a, bus.alu_in_b} !== {1'b1, 1'b0, 1'b0, 3'd0, 16'd0, 3'd0, 16'd0, 16'd0})
      $display("FAIL reset_outputs: ready=%b done=%b ill=%b addr=%0d data=%h sel=%0d a=%h b=%h required 1,0,0,0,0,0,0,0",
               bus.instr_ready, bus.done, bus.illegal, bus.wb_addr, bus.wb_data,
               bus.alu_select, bus.alu_in_a, bus.alu_in_b);
    else n_pass++;
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.instr_ready !== 1'b1)
      $display("FAIL reset_release_ready: ready=%b required 1", bus.instr_ready);
    else n_pass++;
    for (int k = 0; k < 8; k++)
      run_instr($sformatf("reset_read_r%0d", k), enc_r(3'(k), 3'(k), ALU_OR), 3'(k), 16'h0000);
  endtask

  task automatic test_addi();
    run_instr("addi_r1_5", enc_i(3'd1, 8'd5, ALU_ADD), 3'd1, 16'h0005);
  endtask

  task automatic test_rtype();
    run_instr("addi_r2_3", enc_i(3'd2, 8'd3, ALU_ADD), 3'd2, 16'h0003);
    run_instr("sub_r1_r2", enc_r(3'd1, 3'd2, ALU_SUB), 3'd1, 16'h0002);
    run_instr("cmp_r2_r1", enc_r(3'd2, 3'd1, ALU_CMP), 3'd2, 16'h0002);
    run_instr("cmp_r1_r1", enc_r(3'd1, 3'd1, ALU_CMP), 3'd1, 16'h0000);
    run_instr("addi_r4_c", enc_i(3'd4, 8'h0C, ALU_ADD), 3'd4, 16'h000C);
    run_instr("xor_r4_r2", enc_r(3'd4, 3'd2, ALU_XOR), 3'd4, 16'h000E);
    run_instr("shl_r4_r2", enc_r(3'd4, 3'd2, ALU_SHL), 3'd4, 16'h0038);
    run_instr("shri_r4_3", enc_i(3'd4, 8'd3, ALU_SHR), 3'd4, 16'h0007);
    run_instr("and_r4_r2", enc_r(3'd4, 3'd2, ALU_AND), 3'd4, 16'h0002);
    run_instr("ori_r4_f0", enc_i(3'd4, 8'hF0, ALU_OR), 3'd4, 16'h00F2);
    run_instr("add_r4_r4", enc_r(3'd4, 3'd4, ALU_ADD), 3'd4, 16'h01E4);
  endtask

  task automatic test_imm_ext();
`ifdef IMM_SIGN_EXT_EN
    run_instr("addi_r3_80", enc_i(3'd3, 8'h80, ALU_ADD), 3'd3, 16'hFF80);
`else
    run_instr("addi_r3_80", enc_i(3'd3, 8'h80, ALU_ADD), 3'd3, 16'h0080);
`endif
  endtask

  task automatic test_illegal();
    logic [1:0] fmts [2];
    bit ok;
    fmts[0] = 2'b10;
    fmts[1] = 2'b11;
    for (int f = 0; f < 2; f++) begin
      wait_ready(ok);
      n_checks++;
      if (!ok) $display("FAIL illegal_ready_wait: instr_ready never rose");
      else n_pass++;
      bus.instr_valid = 1'b1;
      bus.instr = {3'd2, 3'd2, 5'b0, ALU_ADD, fmts[f]};
      @(posedge clk);
      #1;
      bus.instr_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({bus.illegal, bus.done, bus.instr_ready} !== 3'b100)
        $display("FAIL illegal_decode_fmt%b: illegal,done,ready=%b required 100", fmts[f],
                 {bus.illegal, bus.done, bus.instr_ready});
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if ({bus.illegal, bus.done, bus.instr_ready} !== 3'b001)
        $display("FAIL illegal_return_fmt%b: illegal,done,ready=%b required 001", fmts[f],
                 {bus.illegal, bus.done, bus.instr_ready});
      else n_pass++;
    end
    run_instr("illegal_r2_kept", enc_r(3'd2, 3'd2, ALU_OR), 3'd2, 16'h0002);
  endtask

  task automatic test_back_to_back();
    bit ok;
    int hs = 0;
    bit seen = 1'b0;
    wait_ready(ok);
    n_checks++;
    if (!ok) $display("FAIL b2b_ready_wait: instr_ready never rose");
    else n_pass++;
    bus.instr_valid = 1'b1;
    bus.instr = enc_i(3'd6, 8'd1, ALU_ADD);
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (bus.instr_ready !== ((i == 0) || (i == 4)))
        $display("FAIL b2b_ready_cycle%0d: ready=%b required %b", i, bus.instr_ready,
                 (i == 0) || (i == 4));
      else n_pass++;
      if (bus.instr_ready && bus.instr_valid) hs++;
      if (i == 3) begin
        n_checks++;
        if ({bus.done, bus.wb_addr, bus.wb_data} !== {1'b1, 3'd6, 16'h0001})
          $display("FAIL b2b_first_wb: done=%b addr=%0d data=%h required 1,6,0001",
                   bus.done, bus.wb_addr, bus.wb_data);
        else n_pass++;
      end
      @(negedge clk);
    end
    bus.instr_valid = 1'b0;
    for (int j = 0; j < 8; j++) begin
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (!seen || bus.wb_addr !== 3'd6 || bus.wb_data !== 16'h0002)
      $display("FAIL b2b_second_wb: seen=%b addr=%0d data=%h required 1,6,0002",
               seen, bus.wb_addr, bus.wb_data);
    else n_pass++;
    n_checks++;
    if (hs != 2) $display("FAIL b2b_accept_count: accepted=%0d required 2", hs);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit any_done = 1'b0;
    wait_ready(ok);
    n_checks++;
    if (!ok) $display("FAIL rstmid_ready_wait: instr_ready never rose");
    else n_pass++;
    bus.instr_valid = 1'b1;
    bus.instr = enc_i(3'd7, 8'd7, ALU_ADD);
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({bus.alu_select, bus.alu_in_a, bus.alu_in_b} !== {ALU_ADD, 16'h0000, 16'h0007})
      $display("FAIL rstmid_execute_operands: sel=%0d a=%h b=%h required 0,0000,0007",
               bus.alu_select, bus.alu_in_a, bus.alu_in_b);
    else n_pass++;
    #1 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.alu_select, bus.alu_in_a, bus.alu_in_b, bus.done, bus.wb_addr, bus.wb_data,
         bus.instr_ready} !== {3'd0, 16'd0, 16'd0, 1'b0, 3'd0, 16'd0, 1'b1})
      $display("FAIL rstmid_async_clear: sel=%0d a=%h b=%h done=%b addr=%0d data=%h ready=%b required all 0, ready 1",
               bus.alu_select, bus.alu_in_a, bus.alu_in_b, bus.done, bus.wb_addr,
               bus.wb_data, bus.instr_ready);
    else n_pass++;
    repeat (2) begin
      @(negedge clk);
      if (bus.done === 1'b1) any_done = 1'b1;
    end
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.done === 1'b1) any_done = 1'b1;
    end
    n_checks++;
    if (any_done) $display("FAIL rstmid_no_done: done=1 required 0");
    else n_pass++;
    run_instr("rstmid_r7_zero", enc_r(3'd7, 3'd7, ALU_OR), 3'd7, 16'h0000);
    run_instr("rstmid_r4_zero", enc_r(3'd4, 3'd4, ALU_OR), 3'd4, 16'h0000);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr = '0;
    @(negedge clk);
    test_reset();
    test_addi();
    test_rtype();
    test_imm_ext();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
